// File: rtl/col_fifo_bank.sv
// rtl/col_fifo_bank.sv - bank of COL independent synchronous FIFOs, one per array output column
// Optional sticky overflow/underflow flags are built when COL_FIFO_ERR_EN is defined.
module col_fifo_bank #(
  parameter int COL   = 3,
  parameter int W     = 9,
  parameter int DEPTH = 16
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic [W*COL-1:0] i_data,
  input  logic [COL-1:0]   i_wr_en,
  input  logic [COL-1:0]   i_rd_en,
  output logic [W*COL-1:0] o_data,
  output logic [COL-1:0]   o_fifo_empty,
  output logic [COL-1:0]   o_fifo_full
`ifdef COL_FIFO_ERR_EN
  ,
  input  logic             i_err_clr,
  output logic [COL-1:0]   o_overflow,
  output logic [COL-1:0]   o_underflow
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  for (genvar c = 0; c < COL; c++) begin : g_col
    // Column 0 sits at the MSB end of the packed data buses.
    localparam int HI = (COL - c) * W - 1;

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] cnt;
    logic [W-1:0]  rd_q;
    logic          empty;
    logic          full;
    logic          wr_ok;
    logic          rd_ok;

    // Flags decode straight from cnt so a reset clears them without a clock edge.
    assign empty = (cnt == '0);
    assign full  = (cnt == CW'(DEPTH));
    assign wr_ok = i_wr_en[c] && !full;
    assign rd_ok = i_rd_en[c] && !empty;

    assign o_data[HI -: W]  = rd_q;
    assign o_fifo_empty[c]  = empty;
    assign o_fifo_full[c]   = full;

    // Storage array; contents survive reset, only the pointers are cleared.
    always_ff @(posedge i_clk) begin
      if (wr_ok) begin
        mem[wr_ptr] <= i_data[HI -: W];
      end
    end

    // Pointers, occupancy and the registered read port.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        cnt    <= '0;
        rd_q   <= '0;
      end else begin
        if (wr_ok) begin
          wr_ptr <= wr_ptr + AW'(1);
        end
        if (rd_ok) begin
          rd_q   <= mem[rd_ptr];
          rd_ptr <= rd_ptr + AW'(1);
        end
        case ({wr_ok, rd_ok})
          2'b10:   cnt <= cnt + CW'(1);
          2'b01:   cnt <= cnt - CW'(1);
          default: cnt <= cnt;
        endcase
      end
    end

`ifdef COL_FIFO_ERR_EN
    logic ovf_q;
    logic unf_q;

    assign o_overflow[c]  = ovf_q;
    assign o_underflow[c] = unf_q;

    // Sticky error flags; a new event in the same cycle beats the clear.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
        ovf_q <= 1'b0;
        unf_q <= 1'b0;
      end else begin
        if (i_wr_en[c] && full) begin
          ovf_q <= 1'b1;
        end else if (i_err_clr) begin
          ovf_q <= 1'b0;
        end
        if (i_rd_en[c] && empty) begin
          unf_q <= 1'b1;
        end else if (i_err_clr) begin
          unf_q <= 1'b0;
        end
      end
    end
`endif
  end

endmodule

// File: tb/tb_col_fifo_bank.sv
// tb/tb_col_fifo_bank.sv - directed and randomized checks of col_fifo_bank against a queue model
module tb_col_fifo_bank;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Instance A: default geometry, COL=3 DEPTH=16
  logic [26:0] d3_din, d3_dout;
  logic [2:0]  d3_wr, d3_rd, d3_empty, d3_full;
`ifdef COL_FIFO_ERR_EN
  logic        d3_clr;
  logic [2:0]  d3_ovf, d3_unf;
`endif

  col_fifo_bank #(.COL(3), .W(9), .DEPTH(16)) dut3 (
    .i_clk(clk), .i_rst_n(rst_n), .i_data(d3_din), .i_wr_en(d3_wr), .i_rd_en(d3_rd),
    .o_data(d3_dout), .o_fifo_empty(d3_empty), .o_fifo_full(d3_full)
`ifdef COL_FIFO_ERR_EN
    , .i_err_clr(d3_clr), .o_overflow(d3_ovf), .o_underflow(d3_unf)
`endif
  );

  // Instance B: COL=4 DEPTH=4 for random traffic
  logic [35:0] d4_din, d4_dout;
  logic [3:0]  d4_wr, d4_rd, d4_empty, d4_full;
`ifdef COL_FIFO_ERR_EN
  logic        d4_clr;
  logic [3:0]  d4_ovf, d4_unf;
`endif

  col_fifo_bank #(.COL(4), .W(9), .DEPTH(4)) dut4 (
    .i_clk(clk), .i_rst_n(rst_n), .i_data(d4_din), .i_wr_en(d4_wr), .i_rd_en(d4_rd),
    .o_data(d4_dout), .o_fifo_empty(d4_empty), .o_fifo_full(d4_full)
`ifdef COL_FIFO_ERR_EN
    , .i_err_clr(d4_clr), .o_overflow(d4_ovf), .o_underflow(d4_unf)
`endif
  );

  // Reference model for instance B: one queue per column plus last read value
  logic [8:0] q [4][$];
  logic [8:0] exp_out [4];
  logic [3:0] exp_ovf, exp_unf;

  task automatic model_step(input logic [3:0] wr, input logic [3:0] rd,
                            input logic [35:0] din, input logic clr);
    for (int c = 0; c < 4; c++) begin
      int  sz = q[c].size();
      bit  is_full = (sz == 4);
      bit  is_empty = (sz == 0);
      if (wr[c] && is_full) exp_ovf[c] = 1'b1;
      else if (clr) exp_ovf[c] = 1'b0;
      if (rd[c] && is_empty) exp_unf[c] = 1'b1;
      else if (clr) exp_unf[c] = 1'b0;
      if (rd[c] && !is_empty) exp_out[c] = q[c].pop_front();
      if (wr[c] && !is_full) q[c].push_back(din[(4-c)*9-1 -: 9]);
    end
  endtask

  task automatic cyc3(input logic [2:0] wr, input logic [2:0] rd, input logic [26:0] d);
    d3_wr = wr; d3_rd = rd; d3_din = d;
    @(posedge clk); #1;
    d3_wr = '0; d3_rd = '0; d3_din = '0;
  endtask

  logic [26:0] held;
  logic [63:0] r64;
  logic [35:0] exp_vec;
  logic [3:0]  exp_e, exp_f;
  int pw, pr;

  initial begin
    rst_n = 1'b0;
    d3_din = '0; d3_wr = '0; d3_rd = '0;
    d4_din = '0; d4_wr = '0; d4_rd = '0;
`ifdef COL_FIFO_ERR_EN
    d3_clr = 1'b0; d4_clr = 1'b0;
`endif
    for (int c = 0; c < 4; c++) exp_out[c] = '0;
    exp_ovf = '0; exp_unf = '0;

    // Reset values
    repeat (3) @(posedge clk);
    #1;
    chk("rst_empty3", 64'(d3_empty), 64'(3'b111));
    chk("rst_full3",  64'(d3_full),  64'(0));
    chk("rst_data3",  64'(d3_dout),  64'(0));
    chk("rst_empty4", 64'(d4_empty), 64'(4'hF));
    rst_n = 1'b1;
    @(posedge clk); #1;

    // One write per column, then a parallel read
    cyc3(3'b111, 3'b000, {9'h1A5, 9'h0F0, 9'h123});
    chk("wr3_empty", 64'(d3_empty), 64'(0));
    cyc3(3'b000, 3'b111, '0);
    chk("rd3_data", 64'(d3_dout), 64'({9'h1A5, 9'h0F0, 9'h123}));
    chk("rd3_empty", 64'(d3_empty), 64'(3'b111));
    cyc3(3'b000, 3'b000, '0);
    chk("rd3_hold", 64'(d3_dout), 64'({9'h1A5, 9'h0F0, 9'h123}));

    // Read of empty column 0 is ignored
    cyc3(3'b000, 3'b001, '0);
    chk("unf_data0", 64'(d3_dout[26:18]), 64'(9'h1A5));
    chk("unf_empty", 64'(d3_empty), 64'(3'b111));
`ifdef COL_FIFO_ERR_EN
    chk("unf_flag", 64'(d3_unf), 64'(3'b001));
    cyc3(3'b000, 3'b000, '0);
    chk("unf_sticky", 64'(d3_unf), 64'(3'b001));
    d3_clr = 1'b1;
    cyc3(3'b000, 3'b000, '0);
    d3_clr = 1'b0;
    chk("unf_clr", 64'(d3_unf), 64'(0));
`endif

    // Fill column 1 to full, overflow attempt, drain in order
    for (int i = 0; i < 16; i++) begin
      chk("fill1_notfull", 64'(d3_full[1]), 64'(0));
      cyc3(3'b010, 3'b000, 27'(i) << 9);
    end
    chk("fill1_full", 64'(d3_full), 64'(3'b010));
    cyc3(3'b010, 3'b000, 27'(9'h1FF) << 9);
    chk("ovf1_full", 64'(d3_full), 64'(3'b010));
`ifdef COL_FIFO_ERR_EN
    chk("ovf1_flag", 64'(d3_ovf), 64'(3'b010));
`endif
    for (int i = 0; i < 16; i++) begin
      cyc3(3'b000, 3'b010, '0);
      chk("drain1", 64'(d3_dout[17:9]), 64'(i));
    end
    chk("drain1_empty", 64'(d3_empty[1]), 64'(1));
    chk("drain1_full", 64'(d3_full[1]), 64'(0));

    // Column 2, simultaneous write+read at cnt=5
    for (int i = 0; i < 5; i++) cyc3(3'b100, 3'b000, 27'(100 + i));
    cyc3(3'b100, 3'b100, 27'(200));
    chk("c5_data", 64'(d3_dout[8:0]), 64'(100));
    for (int i = 0; i < 5; i++) begin
      chk("c5_notempty", 64'(d3_empty[2]), 64'(0));
      cyc3(3'b000, 3'b100, '0);
      chk("c5_order", 64'(d3_dout[8:0]), 64'((i < 4) ? 101 + i : 200));
    end
    chk("c5_empty", 64'(d3_empty[2]), 64'(1));

    // Column 2, simultaneous write+read at cnt=16: write dropped
    for (int i = 0; i < 16; i++) cyc3(3'b100, 3'b000, 27'(300 + i));
    chk("c16_full", 64'(d3_full[2]), 64'(1));
    cyc3(3'b100, 3'b100, 27'(9'h1FF));
    chk("c16_data", 64'(d3_dout[8:0]), 64'(300));
    chk("c16_notfull", 64'(d3_full[2]), 64'(0));
    for (int i = 1; i < 16; i++) begin
      cyc3(3'b000, 3'b100, '0);
      chk("c16_order", 64'(d3_dout[8:0]), 64'(300 + i));
    end
    chk("c16_empty", 64'(d3_empty[2]), 64'(1));

    // Column 2, simultaneous write+read at cnt=0: read ignored
    held = d3_dout;
    cyc3(3'b100, 3'b100, 27'(9'h055));
    chk("c0_hold", 64'(d3_dout), 64'(held));
    chk("c0_notempty", 64'(d3_empty[2]), 64'(0));
    cyc3(3'b000, 3'b100, '0);
    chk("c0_data", 64'(d3_dout[8:0]), 64'(9'h055));
    chk("c0_empty", 64'(d3_empty[2]), 64'(1));

    // Asynchronous reset mid-cycle discards entries without a clock edge
    cyc3(3'b111, 3'b000, {9'h011, 9'h022, 9'h033});
    chk("ar_pre", 64'(d3_empty), 64'(0));
    #3;
    rst_n = 1'b0;
    #1;
    chk("ar_empty", 64'(d3_empty), 64'(3'b111));
    chk("ar_full",  64'(d3_full),  64'(0));
    chk("ar_data",  64'(d3_dout),  64'(0));
`ifdef COL_FIFO_ERR_EN
    chk("ar_ovf",   64'(d3_ovf),   64'(0));
`endif
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Random per-column traffic on the COL=4 DEPTH=4 instance
    for (int cyc = 0; cyc < 600; cyc++) begin
      case ((cyc / 100) % 3)
        0: begin pw = 70; pr = 30; end
        1: begin pw = 30; pr = 70; end
        default: begin pw = 50; pr = 50; end
      endcase
      for (int c = 0; c < 4; c++) begin
        d4_wr[c] = ($urandom_range(0, 99) < pw);
        d4_rd[c] = ($urandom_range(0, 99) < pr);
      end
      r64 = {$urandom(), $urandom()};
      d4_din = r64[35:0];
`ifdef COL_FIFO_ERR_EN
      d4_clr = ($urandom_range(0, 15) == 0);
`endif
      @(posedge clk);
`ifdef COL_FIFO_ERR_EN
      model_step(d4_wr, d4_rd, d4_din, d4_clr);
`else
      model_step(d4_wr, d4_rd, d4_din, 1'b0);
`endif
      #1;
      for (int c = 0; c < 4; c++) begin
        exp_vec[(4-c)*9-1 -: 9] = exp_out[c];
        exp_e[c] = (q[c].size() == 0);
        exp_f[c] = (q[c].size() == 4);
      end
      chk("rnd_empty", 64'(d4_empty), 64'(exp_e));
      chk("rnd_full",  64'(d4_full),  64'(exp_f));
      chk("rnd_data",  64'(d4_dout),  64'(exp_vec));
`ifdef COL_FIFO_ERR_EN
      chk("rnd_ovf",   64'(d4_ovf),   64'(exp_ovf));
      chk("rnd_unf",   64'(d4_unf),   64'(exp_unf));
`endif
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
